fetch_stage: RTL and testbench

//  IF stage of the pipelined MIPS core. Owns the PC and drives the word address into the

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: halt marker, bubble word and FSM states.
package fetch_stage_pkg;

  // Opcode of the instruction memory fill word; fetching it stops the core.
  localparam logic [5:0]  OP_HALT   = 6'b111111;

  // sll $0,$0,0 -- the bubble instruction placed into IF/ID.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds instruction, its PC+4 and a valid flag.
// Priority is reset, then bubble insertion, then hold.
import fetch_stage_pkg::*;

module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc4,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc4,
  output logic        q_valid
);

  // Load a new instruction, insert a bubble, or keep the current contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_instr <= NOP_INSTR;
      q_pc4   <= 32'h0;
      q_valid <= 1'b0;
    end else if (bubble) begin
      q_instr <= NOP_INSTR;
      q_pc4   <= 32'h0;
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_instr <= d_instr;
      q_pc4   <= d_pc4;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, applies redirect/flush/stall, detects the halt
// marker or an out-of-range PC, and feeds the IF/ID register.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  logic         halt_hit;
  logic         ifid_hold;
  logic         ifid_bubble;

  assign pc_plus4 = pc + 32'd4;
  assign halt_hit = (instr[31:26] == OP_HALT) || (pc >= PC_LIMIT);
  assign halted   = (state == ST_HALT);

  // PC and FSM state registers; reset wins over everything, even in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  // Next-PC priority mux and halt FSM: redirect > flush > stall > halt > fetch.
  always_comb begin
    pc_next     = pc;
    state_next  = state;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (redirect_en) begin
          pc_next     = {redirect_pc[31:2], 2'b00};
          ifid_bubble = 1'b1;
        end else if (flush) begin
          pc_next     = pc_plus4;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_hold   = 1'b1;
        end else if (halt_hit) begin
          ifid_bubble = 1'b1;
          state_next  = ST_HALT;
        end else begin
          pc_next     = pc_plus4;
        end
      end
      ST_HALT: begin
        if (stall) ifid_hold = 1'b1;
        else       ifid_bubble = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (ifid_hold),
    .bubble  (ifid_bubble),
    .d_instr (instr),
    .d_pc4   (pc_plus4),
    .q_instr (ifid_instr),
    .q_pc4   (ifid_pc4),
    .q_valid (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner cases, then
// randomized control inputs checked against a rule-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc, instr, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted;

  logic [31:0] mem [128];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc, m_iinstr, m_ipc4;
  logic        m_ivalid, m_halted;

  typedef struct {
    string       name;
    logic        rst, stall, flush, redir;
    logic [31:0] rpc;
    logic [31:0] epc, einstr, epc4;
    logic        evalid, ehalt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  // Instruction memory: combinational read, fill word beyond the end
  assign instr = (pc >= 32'd512) ? 32'hFFFF_FFFF : mem[pc[8:2]];

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instr       (instr),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
  );

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (a >= 32'd512) return 32'hFFFF_FFFF;
    return mem[a[8:2]];
  endfunction

  // One clock of the IF-stage rules, as plain arithmetic on model state
  task automatic modelStep(input logic r, input logic s, input logic f,
                           input logic rd, input logic [31:0] rp);
    logic [31:0] w;
    logic        hit;
    if (r) begin
      m_pc = 32'h0; m_halted = 1'b0;
      m_iinstr = 32'h0; m_ipc4 = 32'h0; m_ivalid = 1'b0;
    end else if (!m_halted) begin
      w   = memRead(m_pc);
      hit = (w[31:26] == 6'h3F) || (m_pc >= 32'd512);
      if (rd) begin
        m_pc = rp & 32'hFFFF_FFFC;
        m_iinstr = 32'h0; m_ipc4 = 32'h0; m_ivalid = 1'b0;
      end else if (f) begin
        m_pc = m_pc + 32'd4;
        m_iinstr = 32'h0; m_ipc4 = 32'h0; m_ivalid = 1'b0;
      end else if (s) begin
        // everything holds
      end else if (hit) begin
        m_halted = 1'b1;
        m_iinstr = 32'h0; m_ipc4 = 32'h0; m_ivalid = 1'b0;
      end else begin
        m_iinstr = w; m_ipc4 = m_pc + 32'd4; m_ivalid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!s) begin
      m_iinstr = 32'h0; m_ipc4 = 32'h0; m_ivalid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model and step past the edge
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic rd, input logic [31:0] rp);
    rst = r; stall = s; flush = f; redirect_en = rd; redirect_pc = rp;
    modelStep(r, s, f, rd, rp);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] epc,
                             input logic [31:0] einstr, input logic [31:0] epc4,
                             input logic evalid, input logic ehalt);
    vectors++;
    if (pc !== epc) begin
      miscompares++;
      $display("[TB] FAIL %s pc: got %h expected %h", name, pc, epc);
    end
    if (ifid_instr !== einstr) begin
      miscompares++;
      $display("[TB] FAIL %s ifid_instr: got %h expected %h", name, ifid_instr, einstr);
    end
    if (ifid_pc4 !== epc4) begin
      miscompares++;
      $display("[TB] FAIL %s ifid_pc4: got %h expected %h", name, ifid_pc4, epc4);
    end
    if (ifid_valid !== evalid) begin
      miscompares++;
      $display("[TB] FAIL %s ifid_valid: got %b expected %b", name, ifid_valid, evalid);
    end
    if (halted !== ehalt) begin
      miscompares++;
      $display("[TB] FAIL %s halted: got %b expected %b", name, halted, ehalt);
    end
  endtask

  function automatic void addVec(input string n, input logic r, input logic s,
                                 input logic f, input logic rd, input logic [31:0] rp,
                                 input logic [31:0] epc, input logic [31:0] ei,
                                 input logic [31:0] ep4, input logic ev, input logic eh);
    vec_t v;
    v.name = n; v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.rpc = rp;
    v.epc = epc; v.einstr = ei; v.epc4 = ep4; v.evalid = ev; v.ehalt = eh;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] w;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;

    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    mem[0]   = 32'h2008_0005;
    mem[1]   = 32'h2009_0003;
    mem[2]   = 32'h0109_5020;
    mem[3]   = 32'hFC00_0000;
    mem[127] = 32'h2010_0001;

    //      name        rst st fl rd rpc           pc            instr         pc4           v  h
    addVec("t1_reset",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t1_f0",      0, 0, 0, 0, 32'h0,        32'h4,        32'h2008_0005, 32'h4,       1, 0);
    addVec("t1_f1",      0, 0, 0, 0, 32'h0,        32'h8,        32'h2009_0003, 32'h8,       1, 0);
    addVec("t1_f2",      0, 0, 0, 0, 32'h0,        32'hC,        32'h0109_5020, 32'hC,       1, 0);
    addVec("t1_halt",    0, 0, 0, 0, 32'h0,        32'hC,        32'h0,        32'h0,        0, 1);
    addVec("t1_stay",    0, 0, 0, 0, 32'h0,        32'hC,        32'h0,        32'h0,        0, 1);
    addVec("t2_reset",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t2_f0",      0, 0, 0, 0, 32'h0,        32'h4,        32'h2008_0005, 32'h4,       1, 0);
    addVec("t2_f1",      0, 0, 0, 0, 32'h0,        32'h8,        32'h2009_0003, 32'h8,       1, 0);
    addVec("t2_stall1",  0, 1, 0, 0, 32'h0,        32'h8,        32'h2009_0003, 32'h8,       1, 0);
    addVec("t2_stall2",  0, 1, 0, 0, 32'h0,        32'h8,        32'h2009_0003, 32'h8,       1, 0);
    addVec("t2_resume",  0, 0, 0, 0, 32'h0,        32'hC,        32'h0109_5020, 32'hC,       1, 0);
    addVec("t2_halt",    0, 0, 0, 0, 32'h0,        32'hC,        32'h0,        32'h0,        0, 1);
    addVec("t3_reset",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t3_f0",      0, 0, 0, 0, 32'h0,        32'h4,        32'h2008_0005, 32'h4,       1, 0);
    addVec("t3_redir",   0, 1, 0, 1, 32'h43,       32'h40,       32'h0,        32'h0,        0, 0);
    addVec("t3_fillhlt", 0, 0, 0, 0, 32'h0,        32'h40,       32'h0,        32'h0,        0, 1);
    addVec("t4_reset",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t4_f0",      0, 0, 0, 0, 32'h0,        32'h4,        32'h2008_0005, 32'h4,       1, 0);
    addVec("t4_f1",      0, 0, 0, 0, 32'h0,        32'h8,        32'h2009_0003, 32'h8,       1, 0);
    addVec("t4_flush",   0, 0, 1, 0, 32'h0,        32'hC,        32'h0,        32'h0,        0, 0);
    addVec("t4_halt",    0, 0, 0, 0, 32'h0,        32'hC,        32'h0,        32'h0,        0, 1);
    addVec("t5_reset",   1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t5_redir",   0, 0, 0, 1, 32'h1FC,      32'h1FC,      32'h0,        32'h0,        0, 0);
    addVec("t5_last",    0, 0, 0, 0, 32'h0,        32'h200,      32'h2010_0001, 32'h200,     1, 0);
    addVec("t5_oor",     0, 0, 0, 0, 32'h0,        32'h200,      32'h0,        32'h0,        0, 1);
    addVec("t6_redir",   0, 0, 1, 1, 32'h10,       32'h200,      32'h0,        32'h0,        0, 1);
    addVec("t6_stall",   0, 1, 0, 0, 32'h0,        32'h200,      32'h0,        32'h0,        0, 1);
    addVec("t6_reset",   1, 0, 0, 1, 32'h10,       32'h0,        32'h0,        32'h0,        0, 0);
    addVec("t6_restart", 0, 0, 0, 0, 32'h0,        32'h4,        32'h2008_0005, 32'h4,       1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].rpc);
      checkOutput(tbl[i].name, tbl[i].epc, tbl[i].einstr, tbl[i].epc4,
                  tbl[i].evalid, tbl[i].ehalt);
    end

    // Random program with sparse halt markers, then random control traffic
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
      mem[i] = w;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rand_reset", m_pc, m_iinstr, m_ipc4, m_ivalid, m_halted);

    for (int n = 0; n < 600; n++) begin
      logic        r, s, f, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) == 0);
      rp = 32'($urandom_range(0, 540));
      applyStimulus(r, s, f, rd, rp);
      checkOutput("rand", m_pc, m_iinstr, m_ipc4, m_ivalid, m_halted);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
